// File: rtl/fir_frame_scheduler.sv
// rtl/fir_frame_scheduler.sv - frame sequencer and coefficient-load arbiter for the two-channel polyphase FIR decimator
module fir_frame_scheduler #(
  parameter int MAC_SIZE   = 255,
  parameter int D          = 100,
  parameter int FS_DIV     = 512,
  parameter int COEFF_SIZE = 16,
  parameter int AW         = $clog2(MAC_SIZE)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  run,
  input  logic                  cfg_req,
  output logic                  cfg_ack,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [COEFF_SIZE-1:0] cfg_data,
  output logic                  cfg_err,
  output logic                  clk_fs,
  output logic                  clk_fs_d0,
  output logic                  clk_fs_d1,
  output logic                  clk_fs_d2,
  output logic                  en_0,
  output logic                  en_1,
  output logic                  c_we,
  output logic [AW-1:0]         c_addr,
  output logic [COEFF_SIZE-1:0] c_in,
  output logic                  mac_done,
  output logic                  out_valid,
  output logic                  out_ch
);

  localparam int TW = $clog2(FS_DIV);
  localparam int DW = $clog2(D + 1);

  localparam logic [TW-1:0] T_LAST = TW'(FS_DIV - 1);
  localparam logic [TW-1:0] T_D0   = TW'(1);
  localparam logic [TW-1:0] T_D1   = TW'(2);
  localparam logic [TW-1:0] T_D2   = TW'(3);
  localparam logic [TW-1:0] T_MAC  = TW'(MAC_SIZE + 3);
  localparam logic [DW-1:0] DEC_LAST = DW'(D - 1);
  localparam logic [AW:0]   MAC_LIM  = (AW + 1)'(MAC_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CFG
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           ftmr_q, ftmr_d;
  logic                    ph_q, ph_d;
  logic [DW-1:0]           dec0_q, dec0_d;
  logic [DW-1:0]           dec1_q, dec1_d;
  logic                    c_we_q, c_we_d;
  logic [AW-1:0]           c_addr_q, c_addr_d;
  logic [COEFF_SIZE-1:0]   c_in_q, c_in_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    in_frame;
  logic                    frame_end;
  logic                    mac_hit;
  logic [DW-1:0]           dec_cur;
  logic                    dec_wrap;
  logic                    accept;
  logic                    addr_ok;
  logic [TW-1:0]           ftmr_inc;

  // A frame is live in RUN and in DRAIN; DRAIN only finishes one already begun.
  assign in_frame  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_end = in_frame && (ftmr_q == T_LAST);
  assign mac_hit   = in_frame && (ftmr_q == T_MAC);
  assign dec_cur   = ph_q ? dec1_q : dec0_q;
  assign dec_wrap  = (dec_cur == DEC_LAST);
  assign ftmr_inc  = frame_end ? '0 : ftmr_q + TW'(1);
  // The window closes in the same cycle cfg_req falls, so that beat is refused.
  assign accept    = (state_q == S_CFG) && cfg_req && cfg_valid;
  assign addr_ok   = ({1'b0, cfg_addr} < MAC_LIM);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      ftmr_q    <= '0;
      ph_q      <= 1'b0;
      dec0_q    <= '0;
      dec1_q    <= '0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      c_in_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ftmr_q    <= ftmr_d;
      ph_q      <= ph_d;
      dec0_q    <= dec0_d;
      dec1_q    <= dec1_d;
      c_we_q    <= c_we_d;
      c_addr_q  <= c_addr_d;
      c_in_q    <= c_in_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state: sequencing, channel phase, decimation counters and write capture.
  always_comb begin
    state_d   = state_q;
    ftmr_d    = ftmr_q;
    ph_d      = ph_q;
    dec0_d    = dec0_q;
    dec1_d    = dec1_q;
    c_we_d    = 1'b0;
    c_addr_d  = c_addr_q;
    c_in_d    = c_in_q;
    cfg_err_d = 1'b0;

    // Phase flips at the frame boundary so the next frame serves the other channel.
    if (frame_end) begin
      ph_d = !ph_q;
    end

    if (mac_hit) begin
      if (ph_q) begin
        dec1_d = dec_wrap ? '0 : dec1_q + DW'(1);
      end else begin
        dec0_d = dec_wrap ? '0 : dec0_q + DW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        ftmr_d = '0;
        if (cfg_req) begin
          state_d = S_CFG;
        end else if (run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ftmr_d = ftmr_inc;
        // An exit request in the frame's last cycle finishes the frame right here.
        if (!run || cfg_req) begin
          if (frame_end) begin
            state_d = cfg_req ? S_CFG : S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        ftmr_d = ftmr_inc;
        if (frame_end) begin
          state_d = cfg_req ? S_CFG : S_IDLE;
        end
      end
      S_CFG: begin
        ftmr_d = '0;
        if (accept) begin
          if (addr_ok) begin
            c_we_d   = 1'b1;
            c_addr_d = cfg_addr;
            c_in_d   = cfg_data;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // Leaving the window restarts filtering from a clean channel/decimation state.
        if (!cfg_req) begin
          state_d = S_IDLE;
          ph_d    = 1'b0;
          dec0_d  = '0;
          dec1_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign clk_fs    = (state_q == S_RUN) && (ftmr_q == '0);
  assign clk_fs_d0 = in_frame && (ftmr_q == T_D0);
  assign clk_fs_d1 = in_frame && (ftmr_q == T_D1);
  assign clk_fs_d2 = in_frame && (ftmr_q == T_D2);
  assign en_0      = in_frame && !ph_q;
  assign en_1      = in_frame && ph_q;
  assign mac_done  = mac_hit;
  assign out_valid = mac_hit && dec_wrap;
  assign out_ch    = mac_hit && dec_wrap && ph_q;
  assign cfg_ack   = (state_q == S_CFG) && cfg_req;
  assign cfg_ready = cfg_ack;
  assign c_we      = c_we_q;
  assign c_addr    = c_addr_q;
  assign c_in      = c_in_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/fir_frame_scheduler.md
# fir_frame_scheduler

Frame sequencer and coefficient-load arbiter for the two-channel polyphase FIR decimator. Produces the sample-rate strobe and its delayed copies, the per-channel enables and the decimated output-valid pulse that drive the sample/coefficient memory controller and MAC. Also grants an external configuration master exclusive access to the coefficient RAM write port, and only between frames.

## Interface

Parameters:
- MAC_SIZE, 255, taps per MAC; coefficient RAM depth
- D, 100, decimation factor per channel
- FS_DIV, 512, clk cycles per input sample frame; must be ≥ MAC_SIZE+5
- COEFF_SIZE, 16, coefficient width
- AW, $clog2(MAC_SIZE), coefficient address width

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- run  in  1  level; request continuous filtering
- cfg_req  in  1  level; request coefficient-load window
- cfg_ack  out  1  high while the write window is open (state CFG)
- cfg_valid  in  1  write beat valid
- cfg_ready  out  1  write beat accepted; equals cfg_ack
- cfg_addr  in  AW  coefficient address
- cfg_data  in  COEFF_SIZE  coefficient value
- cfg_err  out  1  one-cycle pulse on an accepted beat with cfg_addr ≥ MAC_SIZE
- clk_fs, clk_fs_d0, clk_fs_d1, clk_fs_d2  out  1 each  frame strobe and 1/2/3-cycle delayed copies
- en_0, en_1  out  1 each  channel enables, one-hot during RUN
- c_we  out  1  coefficient write strobe
- c_addr  out  AW  coefficient write address
- c_in  out  COEFF_SIZE  coefficient write data
- mac_done  out  1  one-cycle pulse when the frame's MAC sweep ends
- out_valid  out  1  one-cycle pulse when a decimated output is ready
- out_ch  out  1  channel of the current out_valid

## Operation

- States: IDLE, RUN, DRAIN, CFG. Reset → IDLE. All outputs reset to 0. Frame timer ftmr, phase bit ph and dec_cnt_0/1 reset to 0.
- IDLE: cfg_req=1 → CFG next cycle. Otherwise run=1 → RUN with ftmr=0. cfg_req has priority over run.
- RUN: ftmr counts 0..FS_DIV-1 and wraps. Leaving RUN requires run=0 or cfg_req=1 → DRAIN. The request is sampled at any ftmr.
- DRAIN: the current frame completes. At ftmr==FS_DIV-1 → CFG if cfg_req=1, else IDLE. No new clk_fs is issued from DRAIN.
- CFG: cfg_ack=cfg_ready=1. A beat with cfg_valid=1 and cfg_addr<MAC_SIZE produces c_we=1, c_addr=cfg_addr, c_in=cfg_data in the next cycle (registered). A beat with cfg_addr≥MAC_SIZE produces cfg_err=1 in the next cycle and c_we stays 0. When cfg_req falls → IDLE next cycle, cfg_ack falls with it. A beat present in that same cycle is not accepted. On leaving CFG, ftmr, ph and both dec_cnt clear to 0.
- Channel phase: ph toggles at each clk_fs. en_0=!ph and en_1=ph, held for the whole frame. Both are 0 outside RUN/DRAIN.
- Decimation: at mac_done, the active channel's dec_cnt increments. If it equals D-1, it wraps to 0, out_valid=1 and out_ch=ph.
- c_we is never high outside CFG. clk_fs_* are never high in CFG or IDLE.

## Timing

- clk_fs at ftmr==0 in RUN. clk_fs_d0 at ftmr==1, clk_fs_d1 at ftmr==2, clk_fs_d2 at ftmr==3. The delayed strobes still fire in DRAIN for a frame already started.
- MAC sweep runs from clk_fs_d1+1 for MAC_SIZE cycles. mac_done is asserted at ftmr==MAC_SIZE+3. out_valid coincides with mac_done.
- cfg_req→cfg_ack latency: 1 cycle from IDLE. From RUN/DRAIN, the end of the current frame + 1.
- cfg_valid→c_we: 1 cycle. Throughput is 1 beat/cycle.
- The first clk_fs after entering RUN is 1 cycle after the run sample.
- Reset mid-frame or mid-CFG: all strobes and c_we drop immediately (async). Nothing resumes until the next run/cfg_req.
- run toggled 1→0→1 during DRAIN: the drain still completes to IDLE, then RUN re-enters on the next cycle.

## Test plan

- Reset, run=1 for 3·FS_DIV → clk_fs every 512 cycles, d0/d1/d2 at +1/+2/+3, mac_done at ftmr 258, en_0/en_1 alternating per frame.
- run=1 with D=4 for 8 frames → out_valid at frames 7 (ch0) and 8 (ch1) only, out_ch 0 then 1.
- cfg_req raised at ftmr=100 in RUN → no further clk_fs, cfg_ack at frame end+1, mac_done of the drained frame still emitted.
- In CFG, 3 beats addr 0,1,254 data 0x1234,0x8000,0x7FFF → c_we 3 consecutive cycles with matching c_addr/c_in; then addr 255 → cfg_err=1, c_we=0.
- cfg_req and run both high in IDLE → CFG entered and no clk_fs. Drop cfg_req → IDLE, then RUN with ftmr=0, ph=0, dec_cnt=0.
- nrst asserted at ftmr=200 and in CFG mid-beat → all outputs 0 same cycle, state IDLE after release.
